// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the
// pipeline writeback stage, the mul/div unit and the cache miss-return path.
// Writeback always wins. Mul/div and load take turns by round-robin. The
// granted write is registered one cycle before it reaches the regfile.
// A starvation counter raises pipe_hold so the pipeline yields the port.
// Optional feature macro: RF_SCOREBOARD_EN. When it is defined, a pending
// scoreboard of long-latency destinations drives the decode RAW hazard.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DW           = 32,
  parameter int AW           = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [AW-1:0] md_addr,
  input  logic [DW-1:0] md_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_set_addr,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          hazard,
  output logic          pipe_hold,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  // ptr == 0 means mul/div has the next turn; ptr == 1 means load does
  logic          ptr;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_next;
  logic          md_grant;
  logic          ld_grant;
  logic          grant_any;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  // Combinational arbitration: writeback first, then round-robin md/ld
  always_comb begin
    md_grant = 1'b0;
    ld_grant = 1'b0;
    if (!rst && !wb_valid) begin
      if (md_valid && (!ld_valid || !ptr)) begin
        md_grant = 1'b1;
      end else if (ld_valid) begin
        ld_grant = 1'b1;
      end
    end
  end

  assign md_ready = md_grant;
  assign ld_ready = ld_grant;

  // Select the address/data of whichever writer holds the port this cycle
  always_comb begin
    grant_any = 1'b0;
    gnt_addr  = '0;
    gnt_data  = '0;
    if (wb_valid) begin
      grant_any = 1'b1;
      gnt_addr  = wb_addr;
      gnt_data  = wb_data;
    end else if (md_grant) begin
      grant_any = 1'b1;
      gnt_addr  = md_addr;
      gnt_data  = md_data;
    end else if (ld_grant) begin
      grant_any = 1'b1;
      gnt_addr  = ld_addr;
      gnt_data  = ld_data;
    end
  end

  // Next starvation count: clears on any md/ld grant, saturates at the limit
  always_comb begin
    starve_next = starve_cnt;
    if (md_grant || ld_grant) begin
      starve_next = '0;
    end else if ((md_valid || ld_valid) && (starve_cnt < CW'(STARVE_LIMIT))) begin
      starve_next = starve_cnt + CW'(1);
    end
  end

  // Registered write port, round-robin pointer, starvation state and hold flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      ptr        <= 1'b0;
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      rf_we <= grant_any && (gnt_addr != '0);
      if (grant_any) begin
        rf_wa <= gnt_addr;
        rf_wd <= gnt_data;
      end
      if (md_grant) begin
        ptr <= 1'b1;
      end else if (ld_grant) begin
        ptr <= 1'b0;
      end
      starve_cnt <= starve_next;
      pipe_hold  <= (starve_next >= CW'(STARVE_LIMIT));
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [(1<<AW)-1:0] pending;

  // Track outstanding long-latency destinations; a new issue beats a same-cycle retire
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (md_grant) begin
        pending[md_addr] <= 1'b0;
      end
      if (ld_grant) begin
        pending[ld_addr] <= 1'b0;
      end
      if (sb_set && (sb_set_addr != '0)) begin
        pending[sb_set_addr] <= 1'b1;
      end
    end
  end

  assign hazard = !rst &&
                  (((rs_addr != '0) && pending[rs_addr]) ||
                   ((rt_addr != '0) && pending[rt_addr]));
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_set_addr, rs_addr, rt_addr};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter.
// Inputs change 1-2 ns after a rising edge. Ready/hazard outputs are checked
// before the next edge. Registered outputs are checked just after the edge.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          md_valid;
  logic          md_ready;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          sb_set;
  logic [AW-1:0] sb_set_addr;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          hazard;
  logic          pipe_hold;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  int checkCount;
  int errorCount;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .hazard(hazard), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  // 10 ns clock, first rising edge at 5 ns
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive the three write requesters, then let combinational outputs settle
  task automatic applyStimulus(input logic wbV, input logic [AW-1:0] wbA, input logic [DW-1:0] wbD,
                               input logic mdV, input logic [AW-1:0] mdA, input logic [DW-1:0] mdD,
                               input logic ldV, input logic [AW-1:0] ldA, input logic [DW-1:0] ldD);
    wb_valid = wbV; wb_addr = wbA; wb_data = wbD;
    md_valid = mdV; md_addr = mdA; md_data = mdD;
    ld_valid = ldV; ld_addr = ldA; ld_data = ldD;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    idle();
    sb_set = 1'b0; sb_set_addr = '0; rs_addr = '0; rt_addr = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    idle();
    sb_set = 1'b0; sb_set_addr = '0; rs_addr = '0; rt_addr = '0;
    tick();

    // A requester presented while reset is held must not be accepted
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd5, 32'h1, 1'b0, '0, '0);
    checkOutput("md_ready_in_reset", md_ready, 0);
    doReset();

    // Reset state
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_rf_wa", rf_wa, 0);
    checkOutput("rst_rf_wd", rf_wd, 0);
    checkOutput("rst_pipe_hold", pipe_hold, 0);
    checkOutput("rst_hazard", hazard, 0);
    checkOutput("rst_md_ready", md_ready, 0);
    checkOutput("rst_ld_ready", ld_ready, 0);

    // Lone mul/div request accepted immediately, written next cycle
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd5, 32'h12345678, 1'b0, '0, '0);
    checkOutput("lone_md_ready", md_ready, 1);
    checkOutput("lone_ld_ready", ld_ready, 0);
    tick();
    checkOutput("lone_rf_we", rf_we, 1);
    checkOutput("lone_rf_wa", rf_wa, 5);
    checkOutput("lone_rf_wd", rf_wd, 32'h12345678);
    idle();
    tick();
    checkOutput("idle_rf_we", rf_we, 0);

    // Writeback beats mul/div for two cycles, then mul/div gets the port
    applyStimulus(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd7, 32'hBBBB0007, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("wbpri_md_ready%0d", i), md_ready, 0);
      tick();
      checkOutput($sformatf("wbpri_rf_we%0d", i), rf_we, 1);
      checkOutput($sformatf("wbpri_rf_wa%0d", i), rf_wa, 3);
      checkOutput($sformatf("wbpri_rf_wd%0d", i), rf_wd, 32'hAAAA0003);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'hBBBB0007, 1'b0, '0, '0);
    checkOutput("wbdrop_md_ready", md_ready, 1);
    tick();
    checkOutput("wbdrop_rf_we", rf_we, 1);
    checkOutput("wbdrop_rf_wa", rf_wa, 7);
    checkOutput("wbdrop_rf_wd", rf_wd, 32'hBBBB0007);
    idle();

    // Round-robin from a fresh pointer: md, ld, md, ld
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_md_ready%0d", i), md_ready, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr_ld_ready%0d", i), ld_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      checkOutput($sformatf("rr_rf_wa%0d", i), rf_wa, (i % 2 == 0) ? 1 : 2);
      checkOutput($sformatf("rr_rf_wd%0d", i), rf_wd, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    idle();

    // Starvation: load blocked by writeback raises pipe_hold after 4 waits
    doReset();
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 1'b1, 5'd6, 32'h66);
    for (int k = 1; k <= 6; k++) begin
      checkOutput($sformatf("starve_ld_ready%0d", k), ld_ready, 0);
      tick();
      checkOutput($sformatf("starve_hold%0d", k), pipe_hold, (k >= 4) ? 1 : 0);
      checkOutput($sformatf("starve_rf_wa%0d", k), rf_wa, 4);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd6, 32'h66);
    checkOutput("starve_release_ready", ld_ready, 1);
    checkOutput("starve_hold_still", pipe_hold, 1);
    tick();
    checkOutput("starve_ld_rf_wa", rf_wa, 6);
    checkOutput("starve_ld_rf_we", rf_we, 1);
    checkOutput("starve_hold_clear", pipe_hold, 0);
    idle();

    // Write to register 0 handshakes but never enables the regfile
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD);
    checkOutput("r0_ld_ready", ld_ready, 1);
    tick();
    checkOutput("r0_rf_we", rf_we, 0);
    idle();

`ifdef RF_SCOREBOARD_EN
    // Scoreboard: set, same-cycle set beats clear, retire, reset wipe
    doReset();
    sb_set = 1'b1; sb_set_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    rs_addr = 5'd9;
    #1;
    checkOutput("sb_hazard_rs", hazard, 1);
    rs_addr = 5'd0; rt_addr = 5'd9;
    #1;
    checkOutput("sb_hazard_rt", hazard, 1);
    rt_addr = 5'd0; rs_addr = 5'd9;
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    idle();
    checkOutput("sb_wb_no_clear", hazard, 1);
    sb_set = 1'b1; sb_set_addr = 5'd9;
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h9, 1'b0, '0, '0);
    checkOutput("sb_md_ready", md_ready, 1);
    tick();
    sb_set = 1'b0;
    #1;
    checkOutput("sb_set_wins", hazard, 1);
    tick();
    idle();
    checkOutput("sb_cleared", hazard, 0);
    sb_set = 1'b1; sb_set_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    #1;
    checkOutput("sb_reset_pre", hazard, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("sb_reset_clear", hazard, 0);
`else
    // Without the scoreboard the hazard output stays low
    sb_set = 1'b1; sb_set_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    rs_addr = 5'd9; rt_addr = 5'd9;
    #1;
    checkOutput("nosb_hazard", hazard, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
